prio_encoder_rr: RTL and testbench

- Parametrised, registered successor to the 8:3 one-hot encoder.
- Accepts an N-bit request vector with any number of bits set, which need not be one-hot.
- Selects one request by fixed priority or round-robin and presents its binary index plus one-hot grant on a valid/ready output handshake.
- Sits between request sources such as interrupt lines or channel requests and a downstream consumer that may stall.

---
 rtl/prio_enc_pkg.sv | 12 +
 rtl/prio_pick.sv | 47 ++++
 rtl/prio_encoder_rr.sv | 73 +++++++
 tb/tb_prio_encoder_rr.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority / round-robin encoder.
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Never returns zero, so a two-input encoder still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational selector: highest set bit (fixed) or first set bit at/after start, wrapping mod N (rr).
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic             rr_en,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             multi
);

  localparam int SW = IDX_W + 1;

  logic [IDX_W-1:0] rr_pos [N];
  logic [N-1:0]     scan;
  logic [IDX_W-1:0] first;

  // scan[0] is the highest-priority slot in either mode: the rotated position
  // start+gi for round-robin, or the reversed position N-1-gi for fixed priority.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_scan
      logic [SW-1:0] sum;
      assign sum         = {1'b0, start} + SW'(gi);
      assign rr_pos[gi]  = (sum >= SW'(N)) ? IDX_W'(sum - SW'(N)) : IDX_W'(sum);
      assign scan[gi]    = rr_en ? req[rr_pos[gi]] : req[N-1-gi];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (scan[i]) begin
        found = 1'b1;
        first = IDX_W'(i);
      end
    end
  end

  assign idx   = rr_en ? rr_pos[first] : (IDX_W'(N - 1) - first);
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder with valid/ready output and optional round-robin arbitration.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED,
  localparam int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic             out_multi
);

  logic             valid_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [N-1:0]     onehot_reg;
  logic             multi_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             pick_multi;
  logic             stage_free;

  assign stage_free = !valid_reg || out_ready;

  // The pointer advanced by this cycle's acceptance already steers the sample
  // taken on the same edge, which keeps back-to-back round-robin fair.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (MODE == MODE_RR && valid_reg && out_ready)
      rr_ptr_next = (idx_reg == IDX_W'(N - 1)) ? '0 : idx_reg + IDX_W'(1);
  end

  prio_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .start (rr_ptr_next),
    .rr_en (MODE == MODE_RR),
    .idx   (pick_idx),
    .found (pick_found),
    .multi (pick_multi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg  <= 1'b0;
      idx_reg    <= '0;
      onehot_reg <= '0;
      multi_reg  <= 1'b0;
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      if (stage_free) begin
        valid_reg  <= pick_found;
        idx_reg    <= pick_found ? pick_idx : '0;
        onehot_reg <= pick_found ? (N'(1) << pick_idx) : '0;
        multi_reg  <= pick_multi;
      end
    end
  end

  assign out_valid  = valid_reg;
  assign out_idx    = idx_reg;
  assign out_onehot = onehot_reg;
  assign out_multi  = multi_reg;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: fixed N=8, round-robin N=8 and round-robin N=5 instances against a behavioural model.
module tb_prio_encoder_rr;
  import prio_enc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] req_f8, req_r8;
  logic [4:0] req_r5;
  logic [2:0] ready;

  logic       v_f8, v_r8, v_r5;
  logic [2:0] idx_f8, idx_r8, idx_r5;
  logic [7:0] oh_f8, oh_r8;
  logic [4:0] oh_r5;
  logic       m_f8, m_r8, m_r5;

  prio_encoder_rr #(.N(8), .MODE(MODE_FIXED)) dut_f8 (
    .clk(clk), .rst(rst), .req(req_f8), .out_ready(ready[0]),
    .out_valid(v_f8), .out_idx(idx_f8), .out_onehot(oh_f8), .out_multi(m_f8));
  prio_encoder_rr #(.N(8), .MODE(MODE_RR)) dut_r8 (
    .clk(clk), .rst(rst), .req(req_r8), .out_ready(ready[1]),
    .out_valid(v_r8), .out_idx(idx_r8), .out_onehot(oh_r8), .out_multi(m_r8));
  prio_encoder_rr #(.N(5), .MODE(MODE_RR)) dut_r5 (
    .clk(clk), .rst(rst), .req(req_r5), .out_ready(ready[2]),
    .out_valid(v_r5), .out_idx(idx_r5), .out_onehot(oh_r5), .out_multi(m_r5));

  int n_of [3] = '{8, 8, 5};
  bit rr_of[3] = '{1'b0, 1'b1, 1'b1};
  int mv[3], midx[3], mmulti[3], mptr[3];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int req_of(input int i);
    case (i)
      0:       return int'(req_f8);
      1:       return int'(req_r8);
      default: return int'(req_r5);
    endcase
  endfunction

  function automatic int exp_oh(input int i);
    return (mv[i] != 0) ? (1 << midx[i]) : 0;
  endfunction

  // Reference: rules applied directly to the sampled vector with plain integers.
  task automatic model_step(input int i, input int r, input bit rdy);
    int n = n_of[i];
    int pc = 0;
    bit acc, free;
    if (rst) begin
      mv[i] = 0; midx[i] = 0; mmulti[i] = 0; mptr[i] = 0;
      return;
    end
    acc  = (mv[i] != 0) && rdy;
    free = (mv[i] == 0) || rdy;
    if (rr_of[i] && acc) mptr[i] = (midx[i] == n - 1) ? 0 : midx[i] + 1;
    if (!free) return;
    for (int b = 0; b < n; b++) if (((r >> b) & 1) != 0) pc++;
    if (pc == 0) begin
      mv[i] = 0; midx[i] = 0; mmulti[i] = 0;
    end else begin
      mv[i] = 1;
      mmulti[i] = (pc >= 2) ? 1 : 0;
      if (!rr_of[i]) begin
        for (int b = 0; b < n; b++) if (((r >> b) & 1) != 0) midx[i] = b;
      end else begin
        for (int k = n - 1; k >= 0; k--)
          if (((r >> ((mptr[i] + k) % n)) & 1) != 0) midx[i] = (mptr[i] + k) % n;
      end
    end
  endtask

  task automatic cycle();
    for (int i = 0; i < 3; i++) model_step(i, req_of(i), ready[i]);
    @(posedge clk);
    #1;
    cyc++;
    check("f8.valid", v_f8, mv[0]);  check("f8.idx", idx_f8, midx[0]);
    check("f8.onehot", oh_f8, exp_oh(0)); check("f8.multi", m_f8, mmulti[0]);
    check("r8.valid", v_r8, mv[1]);  check("r8.idx", idx_r8, midx[1]);
    check("r8.onehot", oh_r8, exp_oh(1)); check("r8.multi", m_r8, mmulti[1]);
    check("r5.valid", v_r5, mv[2]);  check("r5.idx", idx_r5, midx[2]);
    check("r5.onehot", oh_r5, exp_oh(2)); check("r5.multi", m_r5, mmulti[2]);
    $display("cyc %0d rst=%0d f8 v=%0d i=%0d | r8 v=%0d i=%0d | r5 v=%0d i=%0d",
             cyc, rst, v_f8, idx_f8, v_r8, idx_r8, v_r5, idx_r5);
  endtask

  int seq_r8[6] = '{0, 3, 7, 0, 3, 7};
  int seq_r5[4] = '{0, 4, 0, 4};

  initial begin
    for (int i = 0; i < 3; i++) begin mv[i] = 0; midx[i] = 0; mmulti[i] = 0; mptr[i] = 0; end
    rst = 1'b1; req_f8 = 8'hFF; req_r8 = 8'hFF; req_r5 = 5'h1F; ready = 3'b111;
    @(negedge clk);

    // Reset held two cycles with all requests high, then idle.
    cycle(); cycle();
    check("rst.valid", v_f8, 0); check("rst.onehot", oh_r8, 0);
    rst = 1'b0; req_f8 = 8'h00; req_r8 = 8'h00; req_r5 = 5'h00;
    cycle();
    check("idle.valid", v_f8, 0);

    // One-hot walk matches the legacy encoder.
    for (int k = 0; k < 8; k++) begin
      req_f8 = 8'(1 << k);
      cycle();
      check("legacy.idx", idx_f8, k);
      check("legacy.multi", m_f8, 0);
    end

    req_f8 = 8'b0010_0110;
    cycle();
    check("fixed.idx", idx_f8, 5); check("fixed.onehot", oh_f8, 8'h20); check("fixed.multi", m_f8, 1);

    // Backpressure: held result ignores a changing req.
    req_f8 = 8'h08;
    cycle();
    ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) req_f8 = 8'h40;
      cycle();
      check("hold.idx", idx_f8, 3); check("hold.valid", v_f8, 1);
    end
    ready[0] = 1'b1;
    cycle();
    check("release.idx", idx_f8, 6);
    req_f8 = 8'h00;

    // Round-robin fairness over three requesters.
    req_r8 = 8'b1000_1001;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr8.seq", idx_r8, seq_r8[k]);
    end
    req_r8 = 8'h00;

    // Non-power-of-two wrap, then reset mid-sequence.
    req_r5 = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("rr5.seq", idx_r5, seq_r5[k]);
    end
    cycle();
    rst = 1'b1;
    cycle();
    check("rr5.rst.valid", v_r5, 0);
    rst = 1'b0;
    cycle();
    check("rr5.post_rst", idx_r5, 0);

    // Random traffic with random stalls and occasional reset.
    for (int k = 0; k < 400; k++) begin
      req_f8 = 8'($urandom);
      req_r8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      req_r5 = 5'($urandom);
      for (int i = 0; i < 3; i++) ready[i] = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
